shot_sequencer: RTL and testbench
=================================

Name: shot_sequencer

Overview:
Turn-based fire controller for the two-turret artillery game. It owns turret aim indices for the left and right players, turns the fire key into a projectile launch, and steps the projectile position once per frame. It detects hit, off-screen or timeout, updates scores and passes the turn to the other player. Its outputs drive the turret-angle sprite selection and the projectile sprite position in the draw/colour-mux logic.

Parameters:
MUZZLE_L_X, 93, left launch point x (px)
MUZZLE_L_Y, 67, left launch point y
MUZZLE_R_X, 550, right launch point x
MUZZLE_R_Y, 437, right launch point y
TGT_L_X0/X1/Y0/Y1, 0/49/0/99, left-player target box (inclusive), hit only by right shots
TGT_R_X0/X1/Y0/Y1, 590/639/380/479, right-player target box (inclusive), hit only by left shots
MAX_FLIGHT, 255, flight-cycle limit before forced miss
WIN_SCORE, 5, score that ends the game (1..15)

Ports:
frame_clk  in  1  frame-rate clock; all logic on rising edge
Reset_n  in  1  asynchronous active-low reset
keycode  in  8  USB keycode: 8'h1A = w (aim up), 8'h16 = s (aim down), 8'h2C = space (fire)
turret_l_idx  out  4  left aim index, 0..8
turret_r_idx  out  4  right aim index, 0..8
active_player  out  1  0 = left, 1 = right
proj_valid  out  1  projectile on screen
proj_x, proj_y  out  10  projectile origin in px
proj_owner  out  1  player that fired the current shot
hit_pulse, miss_pulse  out  1  single-cycle shot result
score_l, score_r  out  4  player scores
game_over  out  1  set when a score reaches WIN_SCORE

Behaviour:
- Reset values: both idx = 4 (0°); active_player = 0; proj_valid = 0; proj_x/y = 0; proj_owner = 0; pulses = 0; scores = 0; game_over = 0; state = AIM; flight counter = 0. Reset is asynchronous and takes effect mid-flight as well.
- Angle map, idx 0..8 = 90, 60, 45, 30, 0, 330, 315, 300, 270 degrees.
- Velocity (dx, dy) in px/frame for the left player: (0,-4) (2,-3) (3,-3) (3,-2) (4,0) (3,2) (3,3) (2,3) (0,4). The right player uses the same table with dx negated.
- States:
  - AIM: only the active player's idx moves. A held w decrements and a held s increments, one step per frame, saturating at 0 and 8.
  - AIM, fire: fire is a rising edge only (keycode == 2C and the previous-cycle keycode != 2C). On a fire edge go to LAUNCH. Fire takes priority over aim in the same cycle; idx is unchanged on that cycle.
  - LAUNCH (1 cycle): load the active muzzle, latch velocity from the current idx, proj_owner = active_player, proj_valid = 1, counter = 0, go to FLIGHT.
  - FLIGHT, each cycle: next = pos + v, computed signed in 11 bits; counter++.
    - Next inside the opponent box: pos = next, go to RESOLVE_HIT.
    - Else next x < 0, x >= 640, y < 0 or y >= 480, or counter reaches MAX_FLIGHT: pos unchanged, go to RESOLVE_MISS.
    - Else pos = next.
  - The owner's own box is never a hit.
- The hit test uses the origin point only, not the 40x10 sprite box.
- Flight cycle k (k >= 1) therefore tests muzzle + k*v.
- RESOLVE_HIT (1 cycle): hit_pulse = 1; proj_valid = 0; increment the owner's score, saturating at 15.
  - If the new score equals WIN_SCORE: set game_over and go to OVER.
  - Else toggle active_player and go to AIM.
- RESOLVE_MISS (1 cycle): miss_pulse = 1; proj_valid = 0; toggle active_player; go to AIM.
- OVER: all keys ignored, outputs held, proj_valid = 0. Only Reset_n leaves OVER.
- Keys are ignored outside AIM, so aiming during flight has no effect.

Optional Feature:
GRAVITY_EN
- Defined: during FLIGHT, dy increases by 1 every 8th flight cycle (counter[2:0] == 7), saturating at +7, so shots follow an arc.
- Undefined: velocity is constant for the whole flight.
- All Test Plan values assume GRAVITY_EN is undefined.

Decomposition:
- Package shot_pkg:
  - state enum (AIM, LAUNCH, FLIGHT, RESOLVE_HIT, RESOLVE_MISS, OVER)
  - keycode constants (KEY_W, KEY_S, KEY_SPACE)
  - SCREEN_W = 640, SCREEN_H = 480, N_ANGLES = 9, IDX_RESET = 4
  - velocity LUT function idx -> signed 4-bit dx, dy
- Sub-module shot_trajectory: holds pos/vel/counter, computes next, and makes the box and bounds compares; reports hit/oob/timeout to the FSM in shot_sequencer.

Test Plan:
- Reset then idle 10 frames -> idx_l = idx_r = 4, active_player = 0, proj_valid = 0, scores 0.
- Hold w 6 frames -> idx_l = 0 (saturates after 4); hold s 12 frames -> idx_l = 8; idx_r stays 4.
- Left idx 4, space edge -> proj at (93,67) after LAUNCH, x += 4 per frame; miss_pulse in flight cycle 137 (next x = 641); active_player = 1; score_l = 0.
- Left idx 5, fire -> flight cycle 166 next = (591,399) is inside the right box -> hit_pulse; score_l = 1; turn goes right. Space held across the turn must not re-fire for the right player.
- MAX_FLIGHT = 10, left idx 4 -> miss_pulse on flight cycle 10, proj_x = 129.
- Score_l = 4 then one more hit -> score_l = 5, game_over = 1; later keys ignored. Reset_n asserted mid-flight -> all outputs at reset values immediately.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared types and constants for the turn-based shot sequencer.
package shot_pkg;

    typedef enum logic [2:0] {
        AIM,
        LAUNCH,
        FLIGHT,
        RESOLVE_HIT,
        RESOLVE_MISS,
        OVER
    } state_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int N_ANGLES = 9;

    localparam logic [3:0] IDX_RESET = 4'd4;

    typedef struct packed {
        logic signed [3:0] dx;
        logic signed [3:0] dy;
    } vel_t;

    // Per-frame velocity for the left player; the right player negates dx.
    function automatic vel_t vel_lut(input logic [3:0] idx);
        vel_t v;
        case (idx)
            4'd0:    begin v.dx = 4'sd0; v.dy = -4'sd4; end
            4'd1:    begin v.dx = 4'sd2; v.dy = -4'sd3; end
            4'd2:    begin v.dx = 4'sd3; v.dy = -4'sd3; end
            4'd3:    begin v.dx = 4'sd3; v.dy = -4'sd2; end
            4'd4:    begin v.dx = 4'sd4; v.dy =  4'sd0; end
            4'd5:    begin v.dx = 4'sd3; v.dy =  4'sd2; end
            4'd6:    begin v.dx = 4'sd3; v.dy =  4'sd3; end
            4'd7:    begin v.dx = 4'sd2; v.dy =  4'sd3; end
            4'd8:    begin v.dx = 4'sd0; v.dy =  4'sd4; end
            default: begin v.dx = 4'sd4; v.dy =  4'sd0; end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/shot_trajectory.sv
// Projectile datapath: position, velocity and flight counter, plus the
// next-position compares that tell the sequencer about a hit, an exit
// from the screen or a flight timeout.
// Optional macro GRAVITY_EN: dy grows by one every 8th flight cycle (max +7).
module shot_trajectory
    import shot_pkg::*;
#(
    parameter int MUZZLE_L_X = 93,
    parameter int MUZZLE_L_Y = 67,
    parameter int MUZZLE_R_X = 550,
    parameter int MUZZLE_R_Y = 437,
    parameter int TGT_L_X0   = 0,
    parameter int TGT_L_X1   = 49,
    parameter int TGT_L_Y0   = 0,
    parameter int TGT_L_Y1   = 99,
    parameter int TGT_R_X0   = 590,
    parameter int TGT_R_X1   = 639,
    parameter int TGT_R_Y0   = 380,
    parameter int TGT_R_Y1   = 479,
    parameter int MAX_FLIGHT = 255
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       load,
    input  logic       step,
    input  logic       launch_player,
    input  logic [3:0] launch_idx,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       owner,
    output logic       hit,
    output logic       miss
);

    localparam logic signed [10:0] L_X0  = 11'(TGT_L_X0);
    localparam logic signed [10:0] L_X1  = 11'(TGT_L_X1);
    localparam logic signed [10:0] L_Y0  = 11'(TGT_L_Y0);
    localparam logic signed [10:0] L_Y1  = 11'(TGT_L_Y1);
    localparam logic signed [10:0] R_X0  = 11'(TGT_R_X0);
    localparam logic signed [10:0] R_X1  = 11'(TGT_R_X1);
    localparam logic signed [10:0] R_Y0  = 11'(TGT_R_Y0);
    localparam logic signed [10:0] R_Y1  = 11'(TGT_R_Y1);
    localparam logic signed [10:0] SCR_W = 11'(SCREEN_W);
    localparam logic signed [10:0] SCR_H = 11'(SCREEN_H);

    logic signed [3:0]  vel_x;
    logic signed [3:0]  vel_y;
    logic [7:0]         counter;
    logic signed [10:0] next_x;
    logic signed [10:0] next_y;
    logic               in_left_box;
    logic               in_right_box;
    logic               in_opp_box;
    logic               off_screen;
    logic               timed_out;
    vel_t               lut_v;

    assign lut_v = vel_lut(launch_idx);

    assign next_x = $signed({1'b0, pos_x}) + $signed({{7{vel_x[3]}}, vel_x});
    assign next_y = $signed({1'b0, pos_y}) + $signed({{7{vel_y[3]}}, vel_y});

    assign in_left_box  = (next_x >= L_X0) && (next_x <= L_X1) &&
                          (next_y >= L_Y0) && (next_y <= L_Y1);
    assign in_right_box = (next_x >= R_X0) && (next_x <= R_X1) &&
                          (next_y >= R_Y0) && (next_y <= R_Y1);
    assign in_opp_box   = owner ? in_left_box : in_right_box;

    assign off_screen = (next_x < 11'sd0) || (next_x >= SCR_W) ||
                        (next_y < 11'sd0) || (next_y >= SCR_H);
    assign timed_out  = ({1'b0, counter} + 9'd1) == 9'(MAX_FLIGHT);

    assign hit  = step && in_opp_box;
    assign miss = step && !in_opp_box && (off_screen || timed_out);

    // Load the muzzle on launch, then advance one velocity step per flight frame.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x   <= '0;
            pos_y   <= '0;
            vel_x   <= '0;
            vel_y   <= '0;
            counter <= '0;
            owner   <= 1'b0;
        end else if (load) begin
            pos_x   <= launch_player ? 10'(MUZZLE_R_X) : 10'(MUZZLE_L_X);
            pos_y   <= launch_player ? 10'(MUZZLE_R_Y) : 10'(MUZZLE_L_Y);
            vel_x   <= launch_player ? -lut_v.dx : lut_v.dx;
            vel_y   <= lut_v.dy;
            counter <= '0;
            owner   <= launch_player;
        end else if (step) begin
            counter <= counter + 8'd1;
            if (!miss) begin
                pos_x <= next_x[9:0];
                pos_y <= next_y[9:0];
            end
`ifdef GRAVITY_EN
            if ((counter[2:0] == 3'd7) && (vel_y != 4'sd7)) begin
                vel_y <= vel_y + 4'sd1;
            end
`endif
        end
    end

endmodule

// File: rtl/shot_sequencer.sv
// Turn-based fire controller: aiming, fire-edge detection, shot lifecycle,
// scoring and turn hand-over for the two-turret artillery game.
// Optional macro GRAVITY_EN (handled in shot_trajectory) bends shots into an arc.
module shot_sequencer #(
    parameter int MUZZLE_L_X = 93,
    parameter int MUZZLE_L_Y = 67,
    parameter int MUZZLE_R_X = 550,
    parameter int MUZZLE_R_Y = 437,
    parameter int TGT_L_X0   = 0,
    parameter int TGT_L_X1   = 49,
    parameter int TGT_L_Y0   = 0,
    parameter int TGT_L_Y1   = 99,
    parameter int TGT_R_X0   = 590,
    parameter int TGT_R_X1   = 639,
    parameter int TGT_R_Y0   = 380,
    parameter int TGT_R_Y1   = 479,
    parameter int MAX_FLIGHT = 255,
    parameter int WIN_SCORE  = 5
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic [3:0] turret_l_idx,
    output logic [3:0] turret_r_idx,
    output logic       active_player,
    output logic       proj_valid,
    output logic [9:0] proj_x,
    output logic [9:0] proj_y,
    output logic       proj_owner,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    import shot_pkg::*;

    state_t     state;
    state_t     next_state;
    logic [7:0] prev_key;
    logic       fire_edge;
    logic       launch;
    logic       step;
    logic       traj_hit;
    logic       traj_miss;
    logic [3:0] aim_idx;
    logic [3:0] owner_score;
    logic [3:0] new_score;
    logic       win;

    // One aim step per held frame, clamped to the angle table.
    function automatic logic [3:0] step_idx(input logic [3:0] idx, input logic [7:0] key);
        logic [3:0] r;
        r = idx;
        if (key == KEY_W && idx != 4'd0) begin
            r = idx - 4'd1;
        end else if (key == KEY_S && idx != 4'(N_ANGLES - 1)) begin
            r = idx + 4'd1;
        end
        return r;
    endfunction

    assign fire_edge   = (keycode == KEY_SPACE) && (prev_key != KEY_SPACE);
    assign aim_idx     = active_player ? turret_r_idx : turret_l_idx;
    assign owner_score = proj_owner ? score_r : score_l;
    assign new_score   = (owner_score == 4'd15) ? 4'd15 : owner_score + 4'd1;
    assign win         = (new_score == 4'(WIN_SCORE));

    shot_trajectory #(
        .MUZZLE_L_X (MUZZLE_L_X),
        .MUZZLE_L_Y (MUZZLE_L_Y),
        .MUZZLE_R_X (MUZZLE_R_X),
        .MUZZLE_R_Y (MUZZLE_R_Y),
        .TGT_L_X0   (TGT_L_X0),
        .TGT_L_X1   (TGT_L_X1),
        .TGT_L_Y0   (TGT_L_Y0),
        .TGT_L_Y1   (TGT_L_Y1),
        .TGT_R_X0   (TGT_R_X0),
        .TGT_R_X1   (TGT_R_X1),
        .TGT_R_Y0   (TGT_R_Y0),
        .TGT_R_Y1   (TGT_R_Y1),
        .MAX_FLIGHT (MAX_FLIGHT)
    ) u_trajectory (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .load          (launch),
        .step          (step),
        .launch_player (active_player),
        .launch_idx    (aim_idx),
        .pos_x         (proj_x),
        .pos_y         (proj_y),
        .owner         (proj_owner),
        .hit           (traj_hit),
        .miss          (traj_miss)
    );

    // State register for the shot lifecycle.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= AIM;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the per-state strobes and shot-result pulses.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        step       = 1'b0;
        proj_valid = 1'b0;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        case (state)
            AIM: begin
                if (fire_edge) begin
                    next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                launch     = 1'b1;
                next_state = FLIGHT;
            end
            FLIGHT: begin
                step       = 1'b1;
                proj_valid = 1'b1;
                if (traj_hit) begin
                    next_state = RESOLVE_HIT;
                end else if (traj_miss) begin
                    next_state = RESOLVE_MISS;
                end
            end
            RESOLVE_HIT: begin
                hit_pulse  = 1'b1;
                next_state = win ? OVER : AIM;
            end
            RESOLVE_MISS: begin
                miss_pulse = 1'b1;
                next_state = AIM;
            end
            OVER: begin
                next_state = OVER;
            end
            default: begin
                next_state = AIM;
            end
        endcase
    end

    // Aim, scoring and turn hand-over; the key history runs every frame so a held space never re-fires.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_key      <= 8'h00;
            turret_l_idx  <= IDX_RESET;
            turret_r_idx  <= IDX_RESET;
            active_player <= 1'b0;
            score_l       <= 4'd0;
            score_r       <= 4'd0;
            game_over     <= 1'b0;
        end else begin
            prev_key <= keycode;
            case (state)
                AIM: begin
                    if (!fire_edge) begin
                        if (active_player) begin
                            turret_r_idx <= step_idx(turret_r_idx, keycode);
                        end else begin
                            turret_l_idx <= step_idx(turret_l_idx, keycode);
                        end
                    end
                end
                RESOLVE_HIT: begin
                    if (proj_owner) begin
                        score_r <= new_score;
                    end else begin
                        score_l <= new_score;
                    end
                    if (win) begin
                        game_over <= 1'b1;
                    end else begin
                        active_player <= ~active_player;
                    end
                end
                RESOLVE_MISS: begin
                    active_player <= ~active_player;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer: two instances (default flight limit
// and a short limit of 10) share stimulus and are compared every frame
// against a shot-level reference model.
module tb_shot_sequencer;

    localparam logic [7:0] K_W     = 8'h1A;
    localparam logic [7:0] K_S     = 8'h16;
    localparam logic [7:0] K_SPACE = 8'h2C;
    localparam logic [7:0] K_NONE  = 8'h00;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b1;
    logic [7:0] keycode   = 8'h00;

    logic [3:0] a_idx_l, a_idx_r, a_score_l, a_score_r;
    logic       a_player, a_valid, a_owner, a_hit, a_miss, a_over;
    logic [9:0] a_x, a_y;

    logic [3:0] b_idx_l, b_idx_r, b_score_l, b_score_r;
    logic       b_player, b_valid, b_owner, b_hit, b_miss, b_over;
    logic [9:0] b_x, b_y;

    int check_count = 0;
    int fail_count  = 0;

    typedef struct {
        int idx_l, idx_r, player, score_l, score_r, over, prev_key;
        int busy, t, k, hit, mx, my, vx, vy, pos_x, pos_y, owner;
    } model_t;

    model_t mdl [2];
    int max_flight [2] = '{255, 10};
    int vel_dx [9] = '{0, 2, 3, 3, 4, 3, 3, 2, 0};
    int vel_dy [9] = '{-4, -3, -3, -2, 0, 2, 3, 3, 4};

    always #5 frame_clk = ~frame_clk;

    shot_sequencer dut (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .keycode       (keycode),
        .turret_l_idx  (a_idx_l),
        .turret_r_idx  (a_idx_r),
        .active_player (a_player),
        .proj_valid    (a_valid),
        .proj_x        (a_x),
        .proj_y        (a_y),
        .proj_owner    (a_owner),
        .hit_pulse     (a_hit),
        .miss_pulse    (a_miss),
        .score_l       (a_score_l),
        .score_r       (a_score_r),
        .game_over     (a_over)
    );

    shot_sequencer #(.MAX_FLIGHT(10)) dut_short (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .keycode       (keycode),
        .turret_l_idx  (b_idx_l),
        .turret_r_idx  (b_idx_r),
        .active_player (b_player),
        .proj_valid    (b_valid),
        .proj_x        (b_x),
        .proj_y        (b_y),
        .proj_owner    (b_owner),
        .hit_pulse     (b_hit),
        .miss_pulse    (b_miss),
        .score_l       (b_score_l),
        .score_r       (b_score_r),
        .game_over     (b_over)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset(input int m);
        mdl[m] = '{idx_l: 4, idx_r: 4, default: 0};
    endtask

    // Work out the whole shot at the fire edge: first flight step k that hits, leaves or times out.
    task automatic planShot(input int m);
        int p, idx, nx, ny, kk;
        bit done, in_box;
        p   = mdl[m].player;
        idx = p ? mdl[m].idx_r : mdl[m].idx_l;
        mdl[m].mx = p ? 550 : 93;
        mdl[m].my = p ? 437 : 67;
        mdl[m].vx = p ? -vel_dx[idx] : vel_dx[idx];
        mdl[m].vy = vel_dy[idx];
        kk   = 0;
        done = 1'b0;
        while (!done) begin
            kk++;
            nx = mdl[m].mx + kk * mdl[m].vx;
            ny = mdl[m].my + kk * mdl[m].vy;
            if (p == 0) in_box = (nx >= 590 && nx <= 639 && ny >= 380 && ny <= 479);
            else        in_box = (nx >= 0 && nx <= 49 && ny >= 0 && ny <= 99);
            if (in_box) begin
                mdl[m].hit = 1;
                done = 1'b1;
            end else if (nx < 0 || nx >= 640 || ny < 0 || ny >= 480 || kk >= max_flight[m]) begin
                mdl[m].hit = 0;
                done = 1'b1;
            end
        end
        mdl[m].k    = kk;
        mdl[m].busy = 1;
        mdl[m].t    = 0;
    endtask

    // Model one frame edge with the key that was presented on it.
    task automatic modelEdge(input int m, input int key);
        int prev, t, k, ns;
        prev = mdl[m].prev_key;
        mdl[m].prev_key = key;
        if (mdl[m].over != 0) return;
        if (mdl[m].busy != 0) begin
            mdl[m].t++;
            t = mdl[m].t;
            k = mdl[m].k;
            if (t == 1) mdl[m].owner = mdl[m].player;
            if (t >= 1 && t <= k) begin
                mdl[m].pos_x = mdl[m].mx + (t - 1) * mdl[m].vx;
                mdl[m].pos_y = mdl[m].my + (t - 1) * mdl[m].vy;
            end else if (t == k + 1) begin
                mdl[m].pos_x = mdl[m].mx + (mdl[m].hit ? k : k - 1) * mdl[m].vx;
                mdl[m].pos_y = mdl[m].my + (mdl[m].hit ? k : k - 1) * mdl[m].vy;
            end else if (t == k + 2) begin
                mdl[m].busy = 0;
                if (mdl[m].hit != 0) begin
                    if (mdl[m].owner != 0) begin
                        ns = (mdl[m].score_r < 15) ? mdl[m].score_r + 1 : 15;
                        mdl[m].score_r = ns;
                    end else begin
                        ns = (mdl[m].score_l < 15) ? mdl[m].score_l + 1 : 15;
                        mdl[m].score_l = ns;
                    end
                    if (ns == 5) mdl[m].over = 1;
                    else         mdl[m].player ^= 1;
                end else begin
                    mdl[m].player ^= 1;
                end
            end
        end else if (key == int'(K_SPACE) && prev != int'(K_SPACE)) begin
            planShot(m);
        end else if (key == int'(K_W)) begin
            if (mdl[m].player != 0) mdl[m].idx_r = (mdl[m].idx_r > 0) ? mdl[m].idx_r - 1 : 0;
            else                    mdl[m].idx_l = (mdl[m].idx_l > 0) ? mdl[m].idx_l - 1 : 0;
        end else if (key == int'(K_S)) begin
            if (mdl[m].player != 0) mdl[m].idx_r = (mdl[m].idx_r < 8) ? mdl[m].idx_r + 1 : 8;
            else                    mdl[m].idx_l = (mdl[m].idx_l < 8) ? mdl[m].idx_l + 1 : 8;
        end
    endtask

    task automatic checkInstance(input int m,
                                 input logic [3:0] il, input logic [3:0] ir,
                                 input logic ap, input logic pv,
                                 input logic [9:0] px, input logic [9:0] py,
                                 input logic po, input logic hp, input logic mp,
                                 input logic [3:0] sl, input logic [3:0] sr,
                                 input logic go);
        int in_flight, resolving;
        in_flight = (mdl[m].busy != 0 && mdl[m].t >= 1 && mdl[m].t <= mdl[m].k) ? 1 : 0;
        resolving = (mdl[m].busy != 0 && mdl[m].t == mdl[m].k + 1) ? 1 : 0;
        checkOutput($sformatf("dut%0d.idx_l", m), int'(il), mdl[m].idx_l);
        checkOutput($sformatf("dut%0d.idx_r", m), int'(ir), mdl[m].idx_r);
        checkOutput($sformatf("dut%0d.active_player", m), int'(ap), mdl[m].player);
        checkOutput($sformatf("dut%0d.proj_valid", m), int'(pv), in_flight);
        checkOutput($sformatf("dut%0d.proj_x", m), int'(px), mdl[m].pos_x);
        checkOutput($sformatf("dut%0d.proj_y", m), int'(py), mdl[m].pos_y);
        checkOutput($sformatf("dut%0d.proj_owner", m), int'(po), mdl[m].owner);
        checkOutput($sformatf("dut%0d.hit_pulse", m), int'(hp), resolving & mdl[m].hit);
        checkOutput($sformatf("dut%0d.miss_pulse", m), int'(mp), resolving & (mdl[m].hit ^ 1));
        checkOutput($sformatf("dut%0d.score_l", m), int'(sl), mdl[m].score_l);
        checkOutput($sformatf("dut%0d.score_r", m), int'(sr), mdl[m].score_r);
        checkOutput($sformatf("dut%0d.game_over", m), int'(go), mdl[m].over);
    endtask

    task automatic checkAll();
        checkInstance(0, a_idx_l, a_idx_r, a_player, a_valid, a_x, a_y, a_owner,
                      a_hit, a_miss, a_score_l, a_score_r, a_over);
        checkInstance(1, b_idx_l, b_idx_r, b_player, b_valid, b_x, b_y, b_owner,
                      b_hit, b_miss, b_score_l, b_score_r, b_over);
    endtask

    // Present a key for one frame, advance the model and compare just after the edge.
    task automatic applyStimulus(input logic [7:0] key);
        keycode = key;
        @(posedge frame_clk);
        modelEdge(0, int'(key));
        modelEdge(1, int'(key));
        #1;
        checkAll();
    endtask

    task automatic runCycles(input int n, input logic [7:0] key);
        for (int i = 0; i < n; i++) applyStimulus(key);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic doReset();
        Reset_n = 1'b0;
        #1;
        modelReset(0);
        modelReset(1);
        checkAll();
        repeat (2) @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rk;
        int r;
        $display("[TB] shot_sequencer bench start");
        #2;
        doReset();

        runCycles(10, K_NONE);
        runCycles(6, K_W);
        runCycles(12, K_S);
        runCycles(4, K_W);

        applyStimulus(K_NONE);
        applyStimulus(K_SPACE);
        runCycles(145, K_NONE);

        applyStimulus(K_SPACE);
        runCycles(150, K_NONE);

        applyStimulus(K_S);
        applyStimulus(K_NONE);
        runCycles(180, K_SPACE);
        runCycles(3, K_NONE);

        for (int n = 0; n < 4; n++) begin
            applyStimulus(K_SPACE);
            runCycles(150, K_NONE);
            applyStimulus(K_SPACE);
            runCycles(175, K_NONE);
        end

        for (int n = 0; n < 30; n++) begin
            rk = 8'($urandom_range(0, 255));
            applyStimulus(rk);
        end

        doReset();
        applyStimulus(K_NONE);
        applyStimulus(K_SPACE);
        runCycles(40, K_NONE);
        doReset();

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 15);
            if (r < 4)       rk = K_W;
            else if (r < 8)  rk = K_S;
            else if (r < 10) rk = K_SPACE;
            else if (r == 10) rk = 8'h04;
            else             rk = K_NONE;
            applyStimulus(rk);
            if (n == 2000) doReset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
